z80_mem_arbiter: RTL and testbench
==================================

# z80_mem_arbiter

Single-clock arbiter that shares the 64 KiB system memory between the tv80s CPU and a DMA/loader requester. CPU ownership is the default. The DMA side wins the bus through the Z80 BUSRQ/BUSAK handshake, then performs single-beat reads and writes. A grant-length limit and a minimum CPU window guarantee the CPU is never starved. The block sits between the tv80s bus pins, the memory array and the test/loader port.

## Interface
Parameters:
- AW, 16, address width
- MAX_GRANT, 64, maximum DMA-owned cycles per tenure (1..255)
- MIN_CPU, 8, minimum cycles between BUSRQ release and the next BUSRQ assertion (1..255)

Ports:
- clk  in  1  system clock, all logic on rising edge
- reset_n  in  1  asynchronous, active-low reset
- cpu_a  in  AW  CPU address bus
- cpu_dout  in  8  CPU write data
- cpu_mreq_n  in  1  CPU memory request
- cpu_wr_n  in  1  CPU write strobe
- cpu_di  out  8  read data to CPU (the memory read data while the CPU owns the bus, else 8'hFF)
- cpu_busrq_n  out  1  bus request to the CPU
- cpu_busak_n  in  1  bus acknowledge from the CPU
- dma_req  in  1  DMA wants the bus (level)
- dma_valid  in  1  DMA access request, valid only while dma_grant=1
- dma_we  in  1  1 = write, 0 = read
- dma_addr  in  AW  DMA address
- dma_wdata  in  8  DMA write data
- dma_grant  out  1  DMA owns the memory
- dma_ack  out  1  access accepted this cycle
- dma_rvalid  out  1  dma_rdata valid (one cycle after the read ack)
- dma_rdata  out  8  DMA read data
- mem_addr  out  AW  memory address
- mem_we  out  1  memory write enable
- mem_wdata  out  8  memory write data
- mem_rdata  in  8  memory registered read data (1-cycle latency)

## Operation
States and transitions:
- CPU_OWN: memory driven by the CPU.
  - cpu_busrq_n=1.
  - mem_we is asserted when cpu_mreq_n=0 and cpu_wr_n=0.
  - Go to REQ when dma_req=1 and gap_cnt=0.
- REQ: cpu_busrq_n=0; memory still muxed to the CPU.
  - Go to GRANT when cpu_busak_n=0.
  - If dma_req drops first, stay in REQ until cpu_busak_n=0, then go to RELEASE without granting. A BUSRQ is never withdrawn before BUSAK.
- GRANT: dma_grant=1; memory muxed to the DMA side; grant_cnt increments every cycle.
  - dma_ack = dma_valid, combinational, same cycle.
  - Go to RELEASE when dma_req=0, or when grant_cnt reaches MAX_GRANT-1 (the ack on that final cycle is still honoured).
- RELEASE: dma_grant=0; cpu_busrq_n=1; gap_cnt loaded with MIN_CPU.
  - Go to CPU_OWN when cpu_busak_n=1.

Counters:
- gap_cnt decrements in CPU_OWN down to 0 and saturates there.
- grant_cnt clears on entry to GRANT.

Memory mux:
- mem_addr, mem_we and mem_wdata come from the CPU in CPU_OWN, REQ and RELEASE.
- They come from the DMA side in GRANT.
- mem_we is 0 in GRANT unless dma_valid=1 and dma_we=1.

DMA read data:
- dma_rvalid pulses one cycle after a read ack.
- dma_rdata = mem_rdata in that cycle; it holds its value otherwise.

## Timing
- Reset values:
  - state=CPU_OWN; gap_cnt=0; grant_cnt=0.
  - cpu_busrq_n=1; dma_grant=0; dma_ack=0; dma_rvalid=0; dma_rdata=0.
  - mem_we follows the CPU mux.
- Registered outputs: cpu_busrq_n, dma_grant, dma_rvalid and dma_rdata change only on clk rising edge or on reset.
- Latency:
  - From dma_req rising in CPU_OWN (gap_cnt=0) to cpu_busrq_n=0: 1 clock.
  - From cpu_busak_n falling to dma_grant=1: 1 clock.
- Throughput: 1 access per cycle while granted.
- Read timing: read ack in cycle N gives dma_rvalid in cycle N+1.
- A read acked on the last grant cycle still delivers dma_rvalid in the following cycle, even though dma_grant=0 by then.
- Write timing: the memory is written at the clock edge ending the ack cycle.
- Reset mid-tenure: cpu_busrq_n returns to 1 immediately, asynchronously, and any pending dma_rvalid is dropped.
- cpu_busak_n is taken as already synchronous to clk; no extra synchroniser.

## Test plan
- Idle CPU: CPU writes 8'h4D to 16'h0002 with dma_req=0 -> mem_we asserts on that cycle; the memory holds 8'h4D; cpu_busrq_n stays 1 throughout.
- Handshake: dma_req=1; CPU acks 3 cycles after cpu_busrq_n falls -> dma_grant rises 1 cycle after busak_n=0; no memory writes from the DMA side before the grant.
- DMA write/readback: write 8'hC9 to 16'h3B49, then read the same address -> dma_ack on both accesses; dma_rvalid one cycle after the read ack with dma_rdata=8'hC9.
- Grant limit (MAX_GRANT=4): dma_req held high with dma_valid=1 on every cycle -> exactly 4 acks, then RELEASE. cpu_busrq_n falls again no earlier than MIN_CPU cycles after busak_n returns high.
- Abort: dma_req drops while in REQ before busak_n falls -> cpu_busrq_n stays 0 until busak_n=0; dma_grant never asserts; state returns to CPU_OWN once busak_n=1.
- Async reset during GRANT -> cpu_busrq_n=1 and dma_grant=0 without waiting for a clock edge; normal operation resumes after reset_n rises.

Source files
------------

// File: rtl/z80_mem_arbiter.sv
// ---------------------------------------------------------------------------
// z80_mem_arbiter
//
// Shares the 64 KiB system memory between the tv80s CPU and a DMA/loader
// requester. The CPU owns the memory by default. The DMA side takes the bus
// through the Z80 BUSRQ/BUSAK handshake and then issues single-beat reads
// and writes, one per cycle. Two counters protect the CPU:
//   - grant_cnt caps a DMA tenure at MAX_GRANT cycles.
//   - gap_cnt keeps BUSRQ released for at least MIN_CPU cycles between
//     tenures.
//
// Parameters
//   AW         address width
//   MAX_GRANT  maximum DMA-owned cycles per tenure (1..255)
//   MIN_CPU    minimum CPU cycles between BUSRQ release and re-assertion
//              (1..255)
//
// Ports
//   clk, reset_n           system clock, asynchronous active-low reset
//   cpu_a, cpu_dout        CPU address and write data
//   cpu_mreq_n, cpu_wr_n   CPU memory request and write strobe
//   cpu_di                 read data to the CPU (8'hFF while DMA owns memory)
//   cpu_busrq_n            registered bus request to the CPU
//   cpu_busak_n            bus acknowledge from the CPU (already synchronous)
//   dma_req                DMA wants the bus (level)
//   dma_valid, dma_we      DMA access strobe and direction (1 = write)
//   dma_addr, dma_wdata    DMA address and write data
//   dma_grant              registered: DMA owns the memory
//   dma_ack                access accepted this cycle (combinational)
//   dma_rvalid, dma_rdata  read data return, one cycle after the read ack
//   mem_addr, mem_we,
//   mem_wdata              memory port driven by the current owner
//   mem_rdata              memory read data (registered, 1-cycle latency)
// ---------------------------------------------------------------------------
module z80_mem_arbiter #(
    parameter int AW        = 16,
    parameter int MAX_GRANT = 64,
    parameter int MIN_CPU   = 8
) (
    input  logic          clk,
    input  logic          reset_n,

    input  logic [AW-1:0] cpu_a,
    input  logic [7:0]    cpu_dout,
    input  logic          cpu_mreq_n,
    input  logic          cpu_wr_n,
    output logic [7:0]    cpu_di,
    output logic          cpu_busrq_n,
    input  logic          cpu_busak_n,

    input  logic          dma_req,
    input  logic          dma_valid,
    input  logic          dma_we,
    input  logic [AW-1:0] dma_addr,
    input  logic [7:0]    dma_wdata,
    output logic          dma_grant,
    output logic          dma_ack,
    output logic          dma_rvalid,
    output logic [7:0]    dma_rdata,

    output logic [AW-1:0] mem_addr,
    output logic          mem_we,
    output logic [7:0]    mem_wdata,
    input  logic [7:0]    mem_rdata
);

    typedef enum logic [1:0] {
        CPU_OWN = 2'd0,
        REQ     = 2'd1,
        GRANT   = 2'd2,
        RELEASE = 2'd3
    } state_t;

    // The last grant cycle is the one where grant_cnt shows MAX_GRANT-1,
    // so a tenure holds exactly MAX_GRANT cycles.
    localparam logic [7:0] GRANT_LAST = 8'(MAX_GRANT - 1);
    localparam logic [7:0] GAP_LOAD   = 8'(MIN_CPU);

    state_t      state_r;
    state_t      state_next_s;
    logic [7:0]  grant_cnt_r;
    logic [7:0]  gap_cnt_r;
    logic        busrq_n_r;
    logic        grant_r;
    logic        rvalid_r;
    logic [7:0]  rdata_hold_r;
    logic        granted_s;
    logic        read_ack_s;

    // Memory mux select: the DMA side owns the memory only in GRANT.
    assign granted_s  = (state_r == GRANT);
    assign read_ack_s = granted_s & dma_valid & ~dma_we;

    // Next-state logic for the ownership handshake.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            CPU_OWN: begin
                if (dma_req && (gap_cnt_r == 8'd0)) begin
                    state_next_s = REQ;
                end else begin
                    state_next_s = CPU_OWN;
                end
            end
            REQ: begin
                // BUSRQ is never withdrawn before BUSAK. If the requester
                // lost interest while waiting, pass through RELEASE without
                // granting so the CPU gets its bus back cleanly.
                if (!cpu_busak_n) begin
                    if (dma_req) begin
                        state_next_s = GRANT;
                    end else begin
                        state_next_s = RELEASE;
                    end
                end else begin
                    state_next_s = REQ;
                end
            end
            GRANT: begin
                if (!dma_req || (grant_cnt_r == GRANT_LAST)) begin
                    state_next_s = RELEASE;
                end else begin
                    state_next_s = GRANT;
                end
            end
            RELEASE: begin
                if (cpu_busak_n) begin
                    state_next_s = CPU_OWN;
                end else begin
                    state_next_s = RELEASE;
                end
            end
            default: begin
                state_next_s = CPU_OWN;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r <= CPU_OWN;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Tenure length counter: cleared on entry to GRANT, counts GRANT cycles.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            grant_cnt_r <= 8'd0;
        end else if ((state_r != GRANT) && (state_next_s == GRANT)) begin
            grant_cnt_r <= 8'd0;
        end else if (state_r == GRANT) begin
            grant_cnt_r <= grant_cnt_r + 8'd1;
        end else begin
            grant_cnt_r <= grant_cnt_r;
        end
    end

    // CPU window counter: reloaded while releasing, drains in CPU_OWN.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            gap_cnt_r <= 8'd0;
        end else if (state_r == RELEASE) begin
            gap_cnt_r <= GAP_LOAD;
        end else if ((state_r == CPU_OWN) && (gap_cnt_r != 8'd0)) begin
            gap_cnt_r <= gap_cnt_r - 8'd1;
        end else begin
            gap_cnt_r <= gap_cnt_r;
        end
    end

    // Handshake outputs, registered from the next state so they line up
    // with the state they describe.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            busrq_n_r <= 1'b1;
            grant_r   <= 1'b0;
        end else begin
            busrq_n_r <= ~((state_next_s == REQ) || (state_next_s == GRANT));
            grant_r   <= (state_next_s == GRANT);
        end
    end

    // Read-return flag and the last returned byte.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rvalid_r     <= 1'b0;
            rdata_hold_r <= 8'h00;
        end else begin
            rvalid_r <= read_ack_s;
            if (rvalid_r) begin
                rdata_hold_r <= mem_rdata;
            end else begin
                rdata_hold_r <= rdata_hold_r;
            end
        end
    end

    assign cpu_busrq_n = busrq_n_r;
    assign dma_grant   = grant_r;
    assign dma_rvalid  = rvalid_r;

    // The memory read port is itself a register, so during the rvalid cycle
    // the byte is taken straight from mem_rdata; outside it the captured copy
    // is held. Both sources only change on a clock edge or on reset.
    assign dma_rdata = rvalid_r ? mem_rdata : rdata_hold_r;

    // Memory port mux and CPU-side read data.
    always_comb begin
        mem_addr  = cpu_a;
        mem_wdata = cpu_dout;
        mem_we    = 1'b0;
        dma_ack   = 1'b0;
        cpu_di    = 8'hFF;
        if (granted_s) begin
            mem_addr  = dma_addr;
            mem_wdata = dma_wdata;
            mem_we    = dma_valid & dma_we;
            dma_ack   = dma_valid;
            cpu_di    = 8'hFF;
        end else begin
            mem_addr  = cpu_a;
            mem_wdata = cpu_dout;
            mem_we    = ~cpu_mreq_n & ~cpu_wr_n;
            dma_ack   = 1'b0;
            cpu_di    = mem_rdata;
        end
    end

endmodule

// File: tb/tb_z80_mem_arbiter.sv
// ---------------------------------------------------------------------------
// Self-checking bench for z80_mem_arbiter (MAX_GRANT=4, MIN_CPU=8).
// A table of CPU-owned vectors exercises the memory mux, then hand-written
// sequences walk the BUSRQ/BUSAK handshake, DMA write/readback, the grant
// limit and CPU window, an aborted request and an asynchronous reset while
// granted. Inputs change 1 ns after the rising edge; outputs are sampled on
// the falling edge.
// ---------------------------------------------------------------------------
module tb_z80_mem_arbiter;

    localparam int AW        = 16;
    localparam int MAX_GRANT = 4;
    localparam int MIN_CPU   = 8;

    logic          clk = 1'b0;
    logic          reset_n;
    logic [AW-1:0] cpu_a;
    logic [7:0]    cpu_dout;
    logic          cpu_mreq_n;
    logic          cpu_wr_n;
    logic [7:0]    cpu_di;
    logic          cpu_busrq_n;
    logic          cpu_busak_n;
    logic          dma_req;
    logic          dma_valid;
    logic          dma_we;
    logic [AW-1:0] dma_addr;
    logic [7:0]    dma_wdata;
    logic          dma_grant;
    logic          dma_ack;
    logic          dma_rvalid;
    logic [7:0]    dma_rdata;
    logic [AW-1:0] mem_addr;
    logic          mem_we;
    logic [7:0]    mem_wdata;
    logic [7:0]    mem_rdata = 8'h00;

    logic [7:0] mem_model [0:65535] = '{default: 8'h00};

    int total  = 0;
    int passed = 0;

    typedef struct {
        logic [15:0] a;
        logic [7:0]  dout;
        logic        mreq_n;
        logic        wr_n;
        logic        dvalid;
        logic        dwe;
        logic [15:0] daddr;
        logic        exp_we;
    } vec_t;

    vec_t vecs [5];

    z80_mem_arbiter #(
        .AW        (AW),
        .MAX_GRANT (MAX_GRANT),
        .MIN_CPU   (MIN_CPU)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .cpu_a       (cpu_a),
        .cpu_dout    (cpu_dout),
        .cpu_mreq_n  (cpu_mreq_n),
        .cpu_wr_n    (cpu_wr_n),
        .cpu_di      (cpu_di),
        .cpu_busrq_n (cpu_busrq_n),
        .cpu_busak_n (cpu_busak_n),
        .dma_req     (dma_req),
        .dma_valid   (dma_valid),
        .dma_we      (dma_we),
        .dma_addr    (dma_addr),
        .dma_wdata   (dma_wdata),
        .dma_grant   (dma_grant),
        .dma_ack     (dma_ack),
        .dma_rvalid  (dma_rvalid),
        .dma_rdata   (dma_rdata),
        .mem_addr    (mem_addr),
        .mem_we      (mem_we),
        .mem_wdata   (mem_wdata),
        .mem_rdata   (mem_rdata)
    );

    always #5 clk = ~clk;

    // Memory with registered read, write on the edge ending the we cycle.
    always @(posedge clk) begin
        if (mem_we) mem_model[mem_addr] <= mem_wdata;
        mem_rdata <= mem_model[mem_addr];
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic settle;
        @(negedge clk);
    endtask

    task automatic chk1(input string name, input logic act, input logic want);
        total++;
        if (act !== want) $display("FAIL %s: got %b expected %b", name, act, want);
        else passed++;
    endtask

    task automatic chk8(input string name, input logic [7:0] act, input logic [7:0] want);
        total++;
        if (act !== want) $display("FAIL %s: got %h expected %h", name, act, want);
        else passed++;
    endtask

    task automatic chk16(input string name, input logic [15:0] act, input logic [15:0] want);
        total++;
        if (act !== want) $display("FAIL %s: got %h expected %h", name, act, want);
        else passed++;
    endtask

    task automatic chki(input string name, input int act, input int want);
        total++;
        if (act != want) $display("FAIL %s: got %0d expected %0d", name, act, want);
        else passed++;
    endtask

    // Counts falling-edge samples with cpu_busrq_n still high, starting in the
    // current cycle; stops in the first cycle where it is low.
    task automatic count_gap(output int n);
        n = 0;
        while (n < 40) begin
            settle;
            if (!cpu_busrq_n) break;
            n++;
            tick;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int n;
        int acks;
        int gcyc;

        vecs[0] = '{16'h0002, 8'h4D, 1'b0, 1'b0, 1'b0, 1'b0, 16'hAAAA, 1'b1};
        vecs[1] = '{16'h1234, 8'hAA, 1'b0, 1'b1, 1'b1, 1'b1, 16'h0010, 1'b0};
        vecs[2] = '{16'hFFFF, 8'h55, 1'b1, 1'b0, 1'b1, 1'b1, 16'h0011, 1'b0};
        vecs[3] = '{16'h8000, 8'h01, 1'b1, 1'b1, 1'b0, 1'b1, 16'h0012, 1'b0};
        vecs[4] = '{16'h0003, 8'h5A, 1'b0, 1'b0, 1'b1, 1'b1, 16'h0013, 1'b1};

        reset_n     = 1'b0;
        cpu_a       = 16'h0000;
        cpu_dout    = 8'h00;
        cpu_mreq_n  = 1'b1;
        cpu_wr_n    = 1'b1;
        cpu_busak_n = 1'b1;
        dma_req     = 1'b0;
        dma_valid   = 1'b0;
        dma_we      = 1'b0;
        dma_addr    = 16'h0000;
        dma_wdata   = 8'h00;

        // Reset values
        repeat (2) tick;
        settle;
        chk1("rst_busrq_n", cpu_busrq_n, 1'b1);
        chk1("rst_grant",   dma_grant,   1'b0);
        chk1("rst_ack",     dma_ack,     1'b0);
        chk1("rst_rvalid",  dma_rvalid,  1'b0);
        chk8("rst_rdata",   dma_rdata,   8'h00);
        chk1("rst_mem_we",  mem_we,      1'b0);
        reset_n = 1'b1;
        tick;

        // CPU-owned mux vectors (dma_req=0, DMA strobes must be ignored)
        for (int i = 0; i < 5; i++) begin
            cpu_a      = vecs[i].a;
            cpu_dout   = vecs[i].dout;
            cpu_mreq_n = vecs[i].mreq_n;
            cpu_wr_n   = vecs[i].wr_n;
            dma_valid  = vecs[i].dvalid;
            dma_we     = vecs[i].dwe;
            dma_addr   = vecs[i].daddr;
            dma_wdata  = 8'hE0;
            settle;
            chk1 ($sformatf("vec%0d_mem_we", i),    mem_we,      vecs[i].exp_we);
            chk16($sformatf("vec%0d_mem_addr", i),  mem_addr,    vecs[i].a);
            chk8 ($sformatf("vec%0d_mem_wdata", i), mem_wdata,   vecs[i].dout);
            chk1 ($sformatf("vec%0d_busrq_n", i),   cpu_busrq_n, 1'b1);
            chk1 ($sformatf("vec%0d_ack", i),       dma_ack,     1'b0);
            tick;
        end
        cpu_mreq_n = 1'b1;
        cpu_wr_n   = 1'b1;
        dma_valid  = 1'b0;
        chk8("idle_mem_0002", mem_model[16'h0002], 8'h4D);
        chk8("idle_mem_0003", mem_model[16'h0003], 8'h5A);
        chk8("idle_mem_0010", mem_model[16'h0010], 8'h00);

        // CPU read path: registered memory data reaches cpu_di next cycle
        cpu_a      = 16'h0002;
        cpu_mreq_n = 1'b0;
        settle;
        tick;
        settle;
        chk8("cpu_di_read", cpu_di, 8'h4D);
        tick;
        cpu_mreq_n = 1'b1;

        // Handshake: BUSAK three cycles after BUSRQ falls
        dma_req   = 1'b1;
        dma_valid = 1'b1;
        dma_we    = 1'b1;
        dma_addr  = 16'h0010;
        dma_wdata = 8'hEE;
        settle;
        chk1("hs_busrq_before_edge", cpu_busrq_n, 1'b1);
        tick;
        for (int i = 0; i < 3; i++) begin
            settle;
            chk1($sformatf("hs_req%0d_busrq_n", i), cpu_busrq_n, 1'b0);
            chk1($sformatf("hs_req%0d_grant", i),   dma_grant,   1'b0);
            chk1($sformatf("hs_req%0d_mem_we", i),  mem_we,      1'b0);
            tick;
        end
        cpu_busak_n = 1'b0;
        settle;
        chk1("hs_grant_same_cycle", dma_grant, 1'b0);
        chk1("hs_mem_we_busak",     mem_we,    1'b0);
        tick;

        // DMA write then readback
        dma_addr  = 16'h3B49;
        dma_wdata = 8'hC9;
        settle;
        chk1 ("g0_grant",   dma_grant,   1'b1);
        chk1 ("g0_busrq_n", cpu_busrq_n, 1'b0);
        chk1 ("g0_ack",     dma_ack,     1'b1);
        chk1 ("g0_mem_we",  mem_we,      1'b1);
        chk16("g0_addr",    mem_addr,    16'h3B49);
        chk8 ("g0_wdata",   mem_wdata,   8'hC9);
        chk8 ("g0_cpu_di",  cpu_di,      8'hFF);
        tick;
        dma_we = 1'b0;
        settle;
        chk1("g1_read_ack", dma_ack,    1'b1);
        chk1("g1_mem_we",   mem_we,     1'b0);
        chk1("g1_rvalid",   dma_rvalid, 1'b0);
        tick;
        dma_valid = 1'b0;
        dma_addr  = 16'h0002;
        settle;
        chk1("g2_rvalid", dma_rvalid, 1'b1);
        chk8("g2_rdata",  dma_rdata,  8'hC9);
        chk1("g2_ack",    dma_ack,    1'b0);
        tick;
        settle;
        chk1("g3_rvalid",     dma_rvalid, 1'b0);
        chk8("g3_rdata_hold", dma_rdata,  8'hC9);
        chk1("g3_grant",      dma_grant,  1'b1);
        tick;
        settle;
        chk1("rel_grant",     dma_grant,   1'b0);
        chk1("rel_busrq_n",   cpu_busrq_n, 1'b1);
        chk8("rel_mem_3b49",  mem_model[16'h3B49], 8'hC9);
        chk8("rel_mem_0010",  mem_model[16'h0010], 8'h00);
        cpu_busak_n = 1'b1;
        tick;

        // Grant limit: CPU window, then MAX_GRANT acks with valid held high
        count_gap(n);
        chki("gap1_cycles", n, MIN_CPU + 1);
        cpu_busak_n = 1'b0;
        tick;
        acks      = 0;
        gcyc      = 0;
        dma_valid = 1'b1;
        dma_we    = 1'b1;
        for (int i = 0; i < 20; i++) begin
            dma_addr  = 16'h0100 + 16'(i);
            dma_wdata = 8'h10 + 8'(i);
            settle;
            if (!dma_grant) break;
            gcyc++;
            if (dma_ack) acks++;
            tick;
        end
        chki("lim_acks",        acks, MAX_GRANT);
        chki("lim_grant_cycles", gcyc, MAX_GRANT);
        chk1("lim_rel_busrq_n", cpu_busrq_n, 1'b1);
        chk1("lim_rel_ack",     dma_ack,     1'b0);
        chk1("lim_rel_mem_we",  mem_we,      1'b0);
        chk8("lim_mem_0100", mem_model[16'h0100], 8'h10);
        chk8("lim_mem_0103", mem_model[16'h0103], 8'h13);
        dma_valid   = 1'b0;
        cpu_busak_n = 1'b1;
        tick;
        chk8("lim_mem_0104", mem_model[16'h0104], 8'h00);
        count_gap(n);
        chki("gap2_cycles", n, MIN_CPU + 1);

        // Abort: dma_req drops in REQ before BUSAK
        dma_req = 1'b0;
        tick;
        for (int i = 0; i < 3; i++) begin
            settle;
            chk1($sformatf("ab%0d_busrq_n", i), cpu_busrq_n, 1'b0);
            chk1($sformatf("ab%0d_grant", i),   dma_grant,   1'b0);
            tick;
        end
        cpu_busak_n = 1'b0;
        settle;
        chk1("ab_busak_busrq_n", cpu_busrq_n, 1'b0);
        tick;
        settle;
        chk1("ab_rel_grant",   dma_grant,   1'b0);
        chk1("ab_rel_busrq_n", cpu_busrq_n, 1'b1);
        cpu_busak_n = 1'b1;
        tick;
        cpu_a      = 16'h0040;
        cpu_dout   = 8'h3C;
        cpu_mreq_n = 1'b0;
        cpu_wr_n   = 1'b0;
        dma_req    = 1'b1;
        settle;
        chk1("ab_cpu_mem_we", mem_we, 1'b1);
        tick;
        cpu_mreq_n = 1'b1;
        cpu_wr_n   = 1'b1;
        count_gap(n);
        chki("gap3_cycles", n + 1, MIN_CPU + 1);
        chk8("ab_mem_0040", mem_model[16'h0040], 8'h3C);

        // Asynchronous reset during GRANT with a read return pending
        cpu_busak_n = 1'b0;
        tick;
        dma_valid = 1'b1;
        dma_we    = 1'b0;
        dma_addr  = 16'h0002;
        settle;
        chk1("ar_grant", dma_grant, 1'b1);
        chk1("ar_ack",   dma_ack,   1'b1);
        tick;
        dma_valid = 1'b0;
        settle;
        chk1("ar_rvalid_pre", dma_rvalid, 1'b1);
        #1;
        reset_n = 1'b0;
        #1;
        chk1("ar_busrq_n", cpu_busrq_n, 1'b1);
        chk1("ar_grant_0", dma_grant,   1'b0);
        chk1("ar_rvalid",  dma_rvalid,  1'b0);
        chk8("ar_rdata",   dma_rdata,   8'h00);
        cpu_busak_n = 1'b1;
        dma_req     = 1'b0;
        tick;
        reset_n = 1'b1;
        tick;

        // Normal operation after reset: CPU write, then 1-clock BUSRQ latency
        cpu_a      = 16'h0005;
        cpu_dout   = 8'h77;
        cpu_mreq_n = 1'b0;
        cpu_wr_n   = 1'b0;
        dma_req    = 1'b1;
        settle;
        chk1("post_mem_we",  mem_we,      1'b1);
        chk1("post_busrq_0", cpu_busrq_n, 1'b1);
        tick;
        cpu_mreq_n = 1'b1;
        cpu_wr_n   = 1'b1;
        settle;
        chk1("post_busrq_1", cpu_busrq_n, 1'b0);
        chk8("post_mem_0005", mem_model[16'h0005], 8'h77);
        tick;

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
